// File: rtl/mem_arbiter.sv
// Byte-serial memory-port controller: arbitrates fetch and load/store word requests
// onto one byte-wide RAM/IO port and assembles little-endian read data.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_cancel,
  output logic                  i_done,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [2:0]            d_size,
  input  logic [31:0]           d_wdata,
  output logic                  d_done,
  output logic [31:0]           d_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_IBEAT, ST_DBEAT, ST_GAP} state_t;

  state_t                r_state;
  logic [1:0]            r_k;
  logic [1:0]            r_last;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  r_we;
  logic                  r_is_fetch;
  logic                  r_kill;
  logic [31:0]           r_wdata;
  logic [31:0]           r_buf;
  logic [SW-1:0]         r_starve;

  logic                  w_pick_i;
  logic                  w_pick_d;
  logic                  w_gnt_i;
  logic                  w_gnt_d;
  logic [1:0]            w_d_last;
  logic [1:0]            w_k_next;
  logic [1:0]            w_lane;
  logic                  w_last_beat;
  logic [31:0]           w_cap;

  // Priority is decided on raw requests; a port still in its done cycle keeps
  // its win but is not granted, so the other side only gets that cycle if it
  // would have won anyway. This is what lets the starve guard actually engage.
  always_comb begin
    w_pick_i    = i_req & ~i_cancel & (~d_req | (r_starve == STARVE_MAX));
    w_pick_d    = d_req & ~w_pick_i;
    w_gnt_i     = w_pick_i & ~i_done;
    w_gnt_d     = w_pick_d & ~d_done;
    w_d_last    = d_size[2] ? 2'd3 : (d_size[1] ? 2'd1 : 2'd0);
    w_k_next    = r_k + 2'd1;
    w_last_beat = (r_k == r_last);
    w_lane      = (r_state == ST_GAP) ? r_last : (r_k - 2'd1);
    w_cap       = r_buf | ({24'd0, mem_din} << {w_lane, 3'b000});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_last     <= '0;
      r_base     <= '0;
      r_we       <= 1'b0;
      r_is_fetch <= 1'b0;
      r_kill     <= 1'b0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_starve   <= '0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
      mem_dout   <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else if (rdy) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_kill <= 1'b0;
          r_k    <= '0;
          r_buf  <= '0;
          if (w_gnt_i || !i_req) begin
            r_starve <= '0;
          end else if (w_gnt_d && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
          end
          if (w_gnt_i) begin
            r_state    <= ST_IBEAT;
            r_base     <= i_addr;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_last     <= 2'd3;
            r_is_fetch <= 1'b1;
            mem_a      <= i_addr;
            mem_wr     <= 1'b0;
            mem_dout   <= '0;
          end else if (w_gnt_d) begin
            r_state    <= ST_DBEAT;
            r_base     <= d_addr;
            r_we       <= d_we;
            r_wdata    <= d_wdata;
            r_last     <= w_d_last;
            r_is_fetch <= 1'b0;
            mem_a      <= d_addr;
            mem_wr     <= d_we;
            mem_dout   <= d_wdata[7:0];
          end
        end

        ST_IBEAT, ST_DBEAT: begin
          if (r_is_fetch && i_cancel) begin
            r_kill <= 1'b1;
          end
          if (r_k != 2'd0) begin
            r_buf <= w_cap;
          end
          if (w_last_beat) begin
            r_state  <= ST_GAP;
            mem_a    <= '0;
            mem_wr   <= 1'b0;
            mem_dout <= '0;
          end else begin
            r_k      <= w_k_next;
            mem_a    <= r_base + ADDR_WIDTH'(w_k_next);
            mem_dout <= r_wdata[{w_k_next, 3'b000} +: 8];
          end
        end

        ST_GAP: begin
          r_state <= ST_IDLE;
          r_k     <= '0;
          r_buf   <= w_cap;
          if (r_is_fetch) begin
            if (!(r_kill || i_cancel)) begin
              i_done  <= 1'b1;
              i_rdata <= w_cap;
            end
          end else begin
            d_done <= 1'b1;
            if (!r_we) begin
              d_rdata <= w_cap;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus randomized single-port
// transactions, checked against a byte-addressed reference memory model.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rdy;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_cancel;
  logic          i_done;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [2:0]    d_size;
  logic [31:0]   d_wdata;
  logic          d_done;
  logic [31:0]   d_rdata;
  logic [7:0]    mem_din = 8'h00;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .i_req(i_req), .i_addr(i_addr), .i_cancel(i_cancel),
    .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_i_rdata;
  logic [31:0] exp_d_rdata;

  // bmem: what the DUT wrote over the bus; pre: initial contents; rmem: reference.
  logic [7:0] bmem [logic [31:0]];
  logic [7:0] pre  [logic [31:0]];
  logic [7:0] rmem [logic [31:0]];

  function automatic logic [7:0] def_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    if (pre.exists(a))  return pre[a];
    return def_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return def_byte(a);
  endfunction

  function automatic int unsigned nbytes(input logic [2:0] s);
    return s[2] ? 4 : (s[1] ? 2 : 1);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int unsigned n);
    logic [31:0] w;
    w = '0;
    for (int unsigned j = 0; j < n; j++) w = w | (32'(ref_rd(a + j)) << (8 * j));
    return w;
  endfunction

  // RAM: byte for an address appears one cycle later; frozen with rdy.
  always @(posedge clk) begin
    if (rst_n && rdy) begin
      if (mem_wr) bmem[mem_a] = mem_dout;
      mem_din <= bus_rd(mem_a);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w, input int unsigned n);
    for (int unsigned j = 0; j < n; j++) begin
      pre[a + j]  = w[8 * j +: 8];
      rmem[a + j] = w[8 * j +: 8];
    end
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_a"}, mem_a, 32'h0);
    chk({tag, "_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, "_dout"}, 32'(mem_dout), 32'h0);
  endtask

  // Called at a negedge with the DUT idle; cancel_beat = n means cancel during GAP.
  task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input int cancel_beat);
    int unsigned n;
    bit          killed;
    logic [31:0] exp_w;
    n      = is_d ? nbytes(size) : 4;
    killed = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    for (int unsigned k = 0; k < n; k++) begin
      chk("beat_addr", mem_a, addr + k);
      chk("beat_wr", 32'(mem_wr), 32'(is_d & we));
      if (is_d) chk("beat_dout", 32'(mem_dout), 32'(wdata[8 * k +: 8]));
      chk("beat_no_done", 32'({i_done, d_done}), 32'h0);
      if (!is_d && cancel_beat == int'(k)) begin
        i_cancel = 1'b1;
        killed   = 1'b1;
      end else begin
        i_cancel = 1'b0;
      end
      @(negedge clk);
    end
    chk_bus_idle("gap");
    if (!is_d && cancel_beat == int'(n)) begin
      i_cancel = 1'b1;
      killed   = 1'b1;
    end else begin
      i_cancel = 1'b0;
    end
    @(negedge clk);
    i_cancel = 1'b0;
    exp_w = ref_word(addr, n);
    if (is_d) begin
      chk("d_done", 32'(d_done), 32'h1);
      if (!we) exp_d_rdata = exp_w;
      chk("d_rdata", d_rdata, exp_d_rdata);
      chk("i_done_quiet", 32'(i_done), 32'h0);
      if (we) for (int unsigned j = 0; j < n; j++) rmem[addr + j] = wdata[8 * j +: 8];
      d_req = 1'b0;
    end else begin
      chk("i_done", 32'(i_done), 32'(!killed));
      if (!killed) exp_i_rdata = exp_w;
      chk("i_rdata", i_rdata, exp_i_rdata);
      chk("d_done_quiet", 32'(d_done), 32'h0);
      i_req = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", 32'({i_done, d_done}), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit          arb_exp_d [6];
    int          got;
    bit          r_is_d;
    bit          r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [31:0] r_wd;
    int          r_cancel;

    arb_exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; rdy = 1'b1;
    i_req = 1'b0; i_addr = '0; i_cancel = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = '0; d_wdata = '0;
    exp_i_rdata = '0; exp_d_rdata = '0;

    repeat (3) @(negedge clk);
    chk_bus_idle("rst");
    chk("rst_done", 32'({i_done, d_done}), 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch of a known instruction word
    preload(32'h100, 32'h00100513, 4);
    run_txn(1'b0, 1'b0, 32'h100, 3'd4, 32'h0, -1);
    chk("fetch_word", i_rdata, 32'h00100513);

    // Halfword store touches exactly two bytes
    run_txn(1'b1, 1'b1, 32'h30001, 3'd2, 32'hAABBCCDD, -1);
    chk("st_b1", 32'(bus_rd(32'h30001)), 32'hDD);
    chk("st_b2", 32'(bus_rd(32'h30002)), 32'hCC);
    chk("st_b0", 32'(bus_rd(32'h30000)), 32'(def_byte(32'h30000)));
    chk("st_b3", 32'(bus_rd(32'h30003)), 32'(def_byte(32'h30003)));

    // Cancel asserted at grant time blocks the fetch
    i_addr = 32'h6000; i_req = 1'b1; i_cancel = 1'b1;
    @(negedge clk);
    chk_bus_idle("cgrant");
    i_req = 1'b0; i_cancel = 1'b0;
    @(negedge clk);
    chk_bus_idle("cgrant2");

    // Cancel in the second beat, then a normal fetch
    run_txn(1'b0, 1'b0, 32'h200, 3'd4, 32'h0, 1);
    run_txn(1'b0, 1'b0, 32'h204, 3'd4, 32'h0, -1);

    // Address wrap
    preload(32'hFFFFFFFF, 32'h7F, 1);
    run_txn(1'b1, 1'b0, 32'hFFFFFFFF, 3'd1, 32'h12345678, -1);
    chk("wrap_byte", d_rdata, 32'h0000007F);
    run_txn(1'b1, 1'b0, 32'hFFFFFFFE, 3'd4, 32'h0, -1);

    // Both ports held: data twice, then fetch via the starve guard
    i_addr = 32'h4000; d_addr = 32'h8000; d_we = 1'b0; d_size = 3'd4; d_wdata = '0;
    i_req = 1'b1; d_req = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      @(negedge clk);
      if (i_done || d_done) begin
        chk("arb_order_d", 32'(d_done), 32'(arb_exp_d[got]));
        chk("arb_order_i", 32'(i_done), 32'(!arb_exp_d[got]));
        if (d_done) chk("arb_d_rdata", d_rdata, ref_word(32'h8000, 4));
        else        chk("arb_i_rdata", i_rdata, ref_word(32'h4000, 4));
        got++;
        if (got == 6) begin
          i_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
    chk("arb_count", 32'(got), 32'd6);
    i_req = 1'b0; d_req = 1'b0;
    exp_i_rdata = ref_word(32'h4000, 4);
    exp_d_rdata = ref_word(32'h8000, 4);
    repeat (8) @(negedge clk);

    // rdy freeze mid word load, then asynchronous reset in a later beat
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000; d_size = 3'd4;
    @(negedge clk);
    chk("ld_b0", mem_a, 32'h5000);
    @(negedge clk);
    chk("ld_b1", mem_a, 32'h5001);
    rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("frz_a", mem_a, 32'h5001);
      chk("frz_wr", 32'(mem_wr), 32'h0);
      chk("frz_done", 32'(d_done), 32'h0);
    end
    rdy = 1'b1;
    @(negedge clk);
    chk("resume_a", mem_a, 32'h5002);
    #1 rst_n = 1'b0;
    #1;
    chk_bus_idle("arst");
    chk("arst_done", 32'({i_done, d_done}), 32'h0);
    chk("arst_i_rdata", i_rdata, 32'h0);
    chk("arst_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 32'(d_done), 32'h0);
    end
    rst_n = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    repeat (2) @(negedge clk);
    chk("post_rst_no_done", 32'(d_done), 32'h0);
    chk("post_rst_a", mem_a, 32'h0);

    // Randomized single-port traffic over a small overlapping region and the wrap point
    for (int t = 0; t < 40; t++) begin
      r_is_d = 1'($urandom_range(0, 1));
      r_we   = 1'($urandom_range(0, 1));
      r_size = 3'($urandom_range(0, 7));
      r_wd   = $urandom;
      if ($urandom_range(0, 3) == 0) r_addr = 32'hFFFFFFFC + $urandom_range(0, 3);
      else                           r_addr = 32'h0001_0000 | ($urandom & 32'hFF);
      if (!r_is_d && $urandom_range(0, 3) == 0) r_cancel = int'($urandom_range(0, 4));
      else                                      r_cancel = -1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(r_is_d, r_we, r_addr, r_size, r_wd, r_cancel);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
